// File: rtl/nios_gpio_pio_if.sv
// Avalon-MM slave bus bundle for the GPIO PIO.
// A write is accepted when chipselect is high and write_n low at a rising clk edge.
// There are no wait states, so no ready signal exists.
// readdata is combinational from address alone and is valid in the same cycle.
interface nios_gpio_pio_if;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata
   );
endinterface

// File: rtl/nios_gpio_pio.sv
// Parametrised GPIO PIO: per-bit direction, atomic set/clear, synchronised inputs,
// edge capture with write-1-to-clear and a maskable level interrupt.
module nios_gpio_pio #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] OUT_RESET = '0,
   parameter logic [WIDTH-1:0] DIR_RESET = '0,
   parameter int               EDGE_TYPE = 0
) (
   input  logic               clk,
   input  logic               reset_n,
   nios_gpio_pio_if.slave     bus,
   input  logic [WIDTH-1:0]   in_port,
   output logic [WIDTH-1:0]   out_port,
   output logic [WIDTH-1:0]   oe_port,
   output logic               irq
);

   localparam logic [2:0] ADDR_DATA    = 3'd0;
   localparam logic [2:0] ADDR_DIR     = 3'd1;
   localparam logic [2:0] ADDR_IRQMASK = 3'd2;
   localparam logic [2:0] ADDR_EDGECAP = 3'd3;
   localparam logic [2:0] ADDR_OUTSET  = 3'd4;
   localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

   logic             wr;
   logic [WIDTH-1:0] wd;
   logic             unused_wd;

   logic [WIDTH-1:0] data_out;
   logic [WIDTH-1:0] dir;
   logic [WIDTH-1:0] irq_mask;
   logic [WIDTH-1:0] edge_capture;
   logic [WIDTH-1:0] in_s1;
   logic [WIDTH-1:0] in_s2;
   logic [WIDTH-1:0] in_prev;
   logic [1:0]       warm;

   logic [WIDTH-1:0] det;
   logic [WIDTH-1:0] clr;
   logic [31:0]      rd;

   assign wr = bus.chipselect & ~bus.write_n;
   assign wd = bus.writedata[WIDTH-1:0];
   // Bits of writedata above WIDTH are deliberately ignored.
   assign unused_wd = ^{1'b0, bus.writedata};

   // Warm-up gates detection until in_s2/in_prev both hold real pin samples.
   always_comb begin
      det = '0;
      if (warm == 2'd3) begin
         case (EDGE_TYPE)
            0:       det = in_s2 & ~in_prev;
            1:       det = ~in_s2 & in_prev;
            default: det = in_s2 ^ in_prev;
         endcase
      end
   end

   always_comb begin
      clr = '0;
      if (wr && (bus.address == ADDR_EDGECAP)) begin
         clr = wd;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         data_out     <= OUT_RESET;
         dir          <= DIR_RESET;
         irq_mask     <= '0;
         edge_capture <= '0;
         in_s1        <= '0;
         in_s2        <= '0;
         in_prev      <= '0;
         warm         <= 2'd0;
      end else begin
         in_s1   <= in_port;
         in_s2   <= in_s1;
         in_prev <= in_s2;
         if (warm != 2'd3) begin
            warm <= warm + 2'd1;
         end
         // A new edge wins over a clear of the same bit.
         edge_capture <= (edge_capture & ~clr) | det;
         if (wr) begin
            case (bus.address)
               ADDR_DATA:    data_out <= wd;
               ADDR_DIR:     dir      <= wd;
               ADDR_IRQMASK: irq_mask <= wd;
               ADDR_OUTSET:  data_out <= data_out | wd;
               ADDR_OUTCLR:  data_out <= data_out & ~wd;
               default:      ;
            endcase
         end
      end
   end

   always_comb begin
      rd = '0;
      case (bus.address)
         ADDR_DATA:    rd[WIDTH-1:0] = (dir & data_out) | (~dir & in_s2);
         ADDR_DIR:     rd[WIDTH-1:0] = dir;
         ADDR_IRQMASK: rd[WIDTH-1:0] = irq_mask;
         ADDR_EDGECAP: rd[WIDTH-1:0] = edge_capture;
         default:      rd = '0;
      endcase
   end

   assign bus.readdata = rd;
   assign out_port     = data_out;
   assign oe_port      = dir;
   assign irq          = |(edge_capture & irq_mask);

endmodule
